ram_burst_master: RTL and testbench

Initiator for the single-port RAM bus (address / MOSI / MISO / write-enable / read-enable, one-cycle read latency, MISO valid only in the enabled cycle after the read strobe). It converts a host burst request into sequential RAM accesses. Write data arrives over a valid/ready stream; read data leaves over a valid/ready stream through a 2-entry buffer. It sits between a DMA/host engine and any RAM model or macro on that bus.

---
 rtl/ram_burst_master.sv | 153 +++++++++++++++
 tb/tb_ram_burst_master.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// rtl/ram_burst_master.sv - burst initiator converting host bursts into single-port RAM accesses
module ram_burst_master #(
    parameter int CAddrLen = 13,
    parameter int CDataLen = 128,
    parameter int CLenLen  = 8
) (
    input  logic                AClkH,
    input  logic                AResetH,
    input  logic                AClkHEn,
    input  logic                AReqStart,
    input  logic                AReqWr,
    input  logic [CAddrLen-1:0] AReqAddr,
    input  logic [CLenLen-1:0]  AReqLen,
    output logic                ABusy,
    output logic                ADone,
    input  logic [CDataLen-1:0] AWrData,
    input  logic                AWrVld,
    output logic                AWrRdy,
    output logic [CDataLen-1:0] ARdData,
    output logic                ARdVld,
    input  logic                ARdRdy,
    output logic [CAddrLen-1:0] AAddr,
    output logic [CDataLen-1:0] AMosi,
    input  logic [CDataLen-1:0] AMiso,
    output logic                AWrEn,
    output logic                ARdEn
);
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CAddrLen-1:0] addr_q, addr_d;
    logic [CLenLen-1:0]  cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                inflight_q, inflight_d;

    logic [CDataLen-1:0] buf_q [2];
    logic                rd_ptr_q;
    logic                wr_ptr_q;
    logic [1:0]          occ_q;
    logic                push;
    logic                pop;
    logic                issue;

    // A read issued last enabled cycle always lands in the buffer on this one
    assign push    = inflight_q;
    assign pop     = ARdVld & ARdRdy;
    assign ARdVld  = (occ_q != 2'd0);
    assign ARdData = ARdVld ? buf_q[rd_ptr_q] : '0;
    assign ADone   = done_q;

    // Next-state, counters and RAM-side strobes
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        inflight_d = 1'b0;
        issue      = 1'b0;
        ABusy      = (state_q != ST_IDLE);
        AWrRdy     = 1'b0;
        AWrEn      = 1'b0;
        ARdEn      = 1'b0;
        AAddr      = addr_q;
        AMosi      = '0;
        case (state_q)
            ST_IDLE: begin
                if (AReqStart) begin
                    addr_d = AReqAddr;
                    cnt_d  = AReqLen;
                    if (AReqLen == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = AReqWr ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                AWrRdy = 1'b1;
                AWrEn  = AWrVld;
                AMosi  = AWrData;
                if (AWrVld) begin
                    addr_d = addr_q + CAddrLen'(1);
                    cnt_d  = cnt_q - CLenLen'(1);
                    if (cnt_q == CLenLen'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_READ: begin
                // Buffered plus in-flight words are capped at two so a push never overflows
                issue = ((occ_q + {1'b0, inflight_q}) < 2'd2);
                ARdEn = issue;
                if (issue) begin
                    inflight_d = 1'b1;
                    addr_d     = addr_q + CAddrLen'(1);
                    cnt_d      = cnt_q - CLenLen'(1);
                    if (cnt_q == CLenLen'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (occ_q == 2'd0)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state register, advancing only on enabled edges
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else if (AClkHEn) begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            inflight_q <= inflight_d;
        end
    end

    // Two-entry read FIFO; simultaneous push and pop leaves occupancy unchanged
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else if (AClkHEn) begin
            if (push) begin
                buf_q[wr_ptr_q] <= AMiso;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (push && !pop) begin
                occ_q <= occ_q + 2'd1;
            end else if (pop && !push) begin
                occ_q <= occ_q - 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_ram_burst_master.sv
// tb/tb_ram_burst_master.sv - scoreboard bench for ram_burst_master
module tb_ram_burst_master;
    localparam int AW = 13;
    localparam int DW = 128;
    localparam int LW = 8;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          en    = 1'b1;
    logic          start = 1'b0;
    logic          wr    = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [LW-1:0] rlen  = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] wdata = '0;
    logic          wvld  = 1'b0;
    logic          wrdy;
    logic [DW-1:0] rdata;
    logic          rvld;
    logic          rrdy  = 1'b0;
    logic [AW-1:0] addr;
    logic [DW-1:0] mosi;
    logic [DW-1:0] miso  = '0;
    logic          wen;
    logic          ren;

    int n_cmp = 0;
    int n_err = 0;
    int n_ovl = 0;

    logic [AW-1:0] expa_q[$];
    logic [DW-1:0] expd_q[$];

    always #5 clk = ~clk;

    ram_burst_master #(.CAddrLen(AW), .CDataLen(DW), .CLenLen(LW)) dut (
        .AClkH(clk), .AResetH(rst), .AClkHEn(en),
        .AReqStart(start), .AReqWr(wr), .AReqAddr(raddr), .AReqLen(rlen),
        .ABusy(busy), .ADone(done),
        .AWrData(wdata), .AWrVld(wvld), .AWrRdy(wrdy),
        .ARdData(rdata), .ARdVld(rvld), .ARdRdy(rrdy),
        .AAddr(addr), .AMosi(mosi), .AMiso(miso), .AWrEn(wen), .ARdEn(ren)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {16'hD00D, 99'd0, a};
    endfunction

    // RAM model: MISO holds valid data only in the enabled cycle after a read strobe
    always @(posedge clk) begin
        if (en) miso <= ren ? pat(addr) : {DW{1'b1}};
    end

    always @(negedge clk) begin
        if (wen && ren) n_ovl++;
    end

    initial begin
        #2000000;
        $display("FAIL timeout no progress");
        $fatal(1);
    end

    task automatic start_burst(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        @(posedge clk); #1;
        en = 1'b1; start = 1'b1; wr = w; raddr = a; rlen = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wvld = 1'b1; wdata = 128'h1234; rrdy = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, wrdy, rvld, wen, ren} !== 6'b0) begin
            n_err++; $display("FAIL reset_ctrl got %b expected 000000", {busy, done, wrdy, rvld, wen, ren});
        end
        n_cmp++;
        if (addr !== '0) begin n_err++; $display("FAIL reset_addr got %h expected 0", addr); end
        n_cmp++;
        if (mosi !== '0) begin n_err++; $display("FAIL reset_mosi got %h expected 0", mosi); end
        n_cmp++;
        if (rdata !== '0) begin n_err++; $display("FAIL reset_rdata got %h expected 0", rdata); end
        @(posedge clk); #1;
        rst = 1'b0; wvld = 1'b0; wdata = '0; rrdy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy, wen, ren} !== 3'b0) begin
            n_err++; $display("FAIL idle_after_reset got %b expected 000", {busy, wen, ren});
        end
    endtask

    task automatic test_write_burst();
        int nw = 0, cyc = 0, last_w = -1, done_cyc = -1;
        logic acc;
        logic busy_at_done = 1'b1;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        expa_q.delete(); expd_q.delete();
        for (int i = 0; i < 4; i++) begin
            expa_q.push_back(13'h10 + 13'(i));
            expd_q.push_back(128'hA0 + 128'(i));
        end
        start_burst(1'b1, 13'h10, 8'd4);
        wvld = 1'b1; wdata = 128'hA0;
        while (cyc < 40 && done_cyc < 0) begin
            @(negedge clk);
            acc = wen;
            if (wen) begin
                nw++;
                n_cmp++;
                if (expa_q.size() == 0) begin
                    n_err++; $display("FAIL wr_beat extra strobe at %h", addr);
                end else begin
                    ea = expa_q.pop_front(); ed = expd_q.pop_front();
                    if (addr !== ea || mosi !== ed) begin
                        n_err++; $display("FAIL wr_beat got %h/%h expected %h/%h", addr, mosi, ea, ed);
                    end
                end
                last_w = cyc;
            end
            if (done) begin done_cyc = cyc; busy_at_done = busy; end
            cyc++;
            @(posedge clk); #1;
            if (acc) wdata = wdata + 128'd1;
            if (nw == 4) wvld = 1'b0;
        end
        n_cmp++;
        if (nw != 4) begin n_err++; $display("FAIL wr_count got %0d expected 4", nw); end
        n_cmp++;
        if (done_cyc != last_w + 1) begin
            n_err++; $display("FAIL wr_done_cycle got %0d expected %0d", done_cyc, last_w + 1);
        end
        n_cmp++;
        if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL wr_busy_drop got %b expected 0", busy_at_done); end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL wr_done_pulse got %b expected 0", done); end
    endtask

    task automatic test_read_burst();
        int ns = 0, nb = 0, cyc = 0, last_pop = -1, done_cyc = -1;
        logic [AW-1:0] a = 13'h1FFE;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        expa_q.delete(); expd_q.delete();
        for (int i = 0; i < 4; i++) begin
            expa_q.push_back(a); expd_q.push_back(pat(a)); a = a + 13'd1;
        end
        rrdy = 1'b1;
        start_burst(1'b0, 13'h1FFE, 8'd4);
        while (cyc < 40 && done_cyc < 0) begin
            @(negedge clk);
            if (ren) begin
                ns++;
                n_cmp++;
                if (expa_q.size() == 0) begin
                    n_err++; $display("FAIL rd_strobe extra strobe at %h", addr);
                end else begin
                    ea = expa_q.pop_front();
                    if (addr !== ea) begin n_err++; $display("FAIL rd_strobe got %h expected %h", addr, ea); end
                end
            end
            if (rvld && rrdy) begin
                nb++;
                n_cmp++;
                if (expd_q.size() == 0) begin
                    n_err++; $display("FAIL rd_beat extra beat %h", rdata);
                end else begin
                    ed = expd_q.pop_front();
                    if (rdata !== ed) begin n_err++; $display("FAIL rd_beat got %h expected %h", rdata, ed); end
                end
                last_pop = cyc;
            end
            if (done) done_cyc = cyc;
            cyc++;
        end
        n_cmp++;
        if (ns != 4 || nb != 4) begin n_err++; $display("FAIL rd_counts got %0d/%0d expected 4/4", ns, nb); end
        n_cmp++;
        if (done_cyc != last_pop + 2) begin
            n_err++; $display("FAIL rd_done_cycle got %0d expected %0d", done_cyc, last_pop + 2);
        end
        @(posedge clk); #1;
        rrdy = 1'b0;
    endtask

    task automatic test_read_backpressure();
        int ns = 0, nb = 0, cyc = 0, done_cyc = -1;
        logic ren_last = 1'b1;
        logic [AW-1:0] a = 13'h100;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        expa_q.delete(); expd_q.delete();
        for (int i = 0; i < 5; i++) begin
            expa_q.push_back(a); expd_q.push_back(pat(a)); a = a + 13'd1;
        end
        rrdy = 1'b0;
        start_burst(1'b0, 13'h100, 8'd5);
        while (cyc < 60 && done_cyc < 0) begin
            if (cyc == 10) begin
                @(posedge clk); #1;
                rrdy = 1'b1;
            end
            @(negedge clk);
            if (ren) begin
                ns++;
                n_cmp++;
                if (expa_q.size() == 0) begin
                    n_err++; $display("FAIL bp_strobe extra strobe at %h", addr);
                end else begin
                    ea = expa_q.pop_front();
                    if (addr !== ea) begin n_err++; $display("FAIL bp_strobe got %h expected %h", addr, ea); end
                end
            end
            if (rvld && rrdy) begin
                nb++;
                n_cmp++;
                if (expd_q.size() == 0) begin
                    n_err++; $display("FAIL bp_beat extra beat %h", rdata);
                end else begin
                    ed = expd_q.pop_front();
                    if (rdata !== ed) begin n_err++; $display("FAIL bp_beat got %h expected %h", rdata, ed); end
                end
            end
            if (cyc == 9) begin
                ren_last = ren;
                n_cmp++;
                if (ns != 2) begin n_err++; $display("FAIL bp_stall_strobes got %0d expected 2", ns); end
            end
            if (done) done_cyc = cyc;
            cyc++;
        end
        n_cmp++;
        if (ren_last !== 1'b0) begin n_err++; $display("FAIL bp_ren_held got %b expected 0", ren_last); end
        n_cmp++;
        if (ns != 5 || nb != 5 || done_cyc < 0) begin
            n_err++; $display("FAIL bp_totals got %0d/%0d done=%0d expected 5/5 done", ns, nb, done_cyc);
        end
        @(posedge clk); #1;
        rrdy = 1'b0;
    endtask

    task automatic test_clken_toggle();
        int nw = 0, cyc = 0, done_cyc = -1;
        logic acc;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        expa_q.delete(); expd_q.delete();
        for (int i = 0; i < 3; i++) begin
            expa_q.push_back(13'h40 + 13'(i));
            expd_q.push_back(128'hC0 + 128'(i));
        end
        start_burst(1'b1, 13'h40, 8'd3);
        en = 1'b0; wvld = 1'b1; wdata = 128'hC0;
        while (cyc < 40 && done_cyc < 0) begin
            @(negedge clk);
            acc = wen && en;
            if (acc) begin
                nw++;
                n_cmp++;
                if (expa_q.size() == 0) begin
                    n_err++; $display("FAIL ce_beat extra write at %h", addr);
                end else begin
                    ea = expa_q.pop_front(); ed = expd_q.pop_front();
                    if (addr !== ea || mosi !== ed) begin
                        n_err++; $display("FAIL ce_beat got %h/%h expected %h/%h", addr, mosi, ea, ed);
                    end
                end
            end
            if (done) done_cyc = cyc;
            cyc++;
            @(posedge clk); #1;
            en = ~en;
            if (acc) wdata = wdata + 128'd1;
            if (nw == 3) wvld = 1'b0;
        end
        en = 1'b1; wvld = 1'b0;
        n_cmp++;
        if (nw != 3 || done_cyc < 0) begin
            n_err++; $display("FAIL ce_totals got %0d done=%0d expected 3 done", nw, done_cyc);
        end
    endtask

    task automatic test_len0_and_ignore();
        int nren = 0;
        start_burst(1'b1, 13'h0AA, 8'd0);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, wen, ren} !== 4'b0100) begin
            n_err++; $display("FAIL len0_done got %b expected 0100", {busy, done, wen, ren});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL len0_after got %b expected 00", {busy, done}); end
        wvld = 1'b0;
        start_burst(1'b1, 13'h200, 8'd2);
        start = 1'b1; wr = 1'b0; raddr = 13'h300; rlen = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wrdy !== 1'b1 || addr !== 13'h200 || ren !== 1'b0) begin
            n_err++; $display("FAIL ignore_start got rdy=%b addr=%h ren=%b expected 1/200/0", wrdy, addr, ren);
        end
        @(posedge clk); #1;
        wvld = 1'b1; wdata = 128'hE0;
        @(negedge clk);
        n_cmp++;
        if (wen !== 1'b1 || addr !== 13'h200 || mosi !== 128'hE0) begin
            n_err++; $display("FAIL ignore_w0 got %b/%h/%h expected 1/200/e0", wen, addr, mosi);
        end
        @(posedge clk); #1;
        wdata = 128'hE1;
        @(negedge clk);
        n_cmp++;
        if (wen !== 1'b1 || addr !== 13'h201 || mosi !== 128'hE1) begin
            n_err++; $display("FAIL ignore_w1 got %b/%h/%h expected 1/201/e1", wen, addr, mosi);
        end
        @(posedge clk); #1;
        wvld = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL ignore_done got %b expected 10", {done, busy}); end
        repeat (4) begin
            @(negedge clk);
            if (ren || busy) nren++;
        end
        n_cmp++;
        if (nren != 0) begin n_err++; $display("FAIL ignore_no_read got %0d expected 0", nren); end
    endtask

    task automatic test_reset_midread();
        int nb = 0, cyc = 0, done_cyc = -1;
        logic [DW-1:0] ed;
        rrdy = 1'b0;
        start_burst(1'b0, 13'h050, 8'd6);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, wrdy, rvld, wen, ren} !== 6'b0 || addr !== '0 || rdata !== '0 || mosi !== '0) begin
            n_err++; $display("FAIL midreset got %b addr=%h rdata=%h expected 0", {busy, done, wrdy, rvld, wen, ren}, addr, rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        expd_q.delete();
        expd_q.push_back(pat(13'h060)); expd_q.push_back(pat(13'h061));
        rrdy = 1'b1;
        start_burst(1'b0, 13'h060, 8'd2);
        while (cyc < 40 && done_cyc < 0) begin
            @(negedge clk);
            if (rvld && rrdy) begin
                nb++;
                n_cmp++;
                if (expd_q.size() == 0) begin
                    n_err++; $display("FAIL post_reset_beat extra beat %h", rdata);
                end else begin
                    ed = expd_q.pop_front();
                    if (rdata !== ed) begin n_err++; $display("FAIL post_reset_beat got %h expected %h", rdata, ed); end
                end
            end
            if (done) done_cyc = cyc;
            cyc++;
        end
        n_cmp++;
        if (nb != 2 || done_cyc < 0) begin
            n_err++; $display("FAIL post_reset_totals got %0d done=%0d expected 2 done", nb, done_cyc);
        end
        @(posedge clk); #1;
        rrdy = 1'b0;
    endtask

    task automatic test_exclusive_strobes();
        n_cmp++;
        if (n_ovl != 0) begin n_err++; $display("FAIL strobe_overlap got %0d expected 0", n_ovl); end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_backpressure();
        test_clken_toggle();
        test_len0_and_ignore();
        test_reset_midread();
        test_exclusive_strobes();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
